idu_pipe: RTL and testbench

- Registered, handshaked successor to the combinational instruction decoder.
- Decodes all RV32 base formats (R/I/S/B/U/J) and flags illegal opcodes.
- Optionally enforces RV32E register limits.
- Sits between IFU and EXU with valid/ready on both sides, a 2-entry skid buffer so in_ready is a flop output, a synchronous flush, and a decoded-instruction counter.

---
 rtl/idu_pipe.sv | 165 ++++++++++++++++
 tb/tb_idu_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// Registered RV32 instruction decoder between IFU and EXU: combinational decode
// of in_inst, a one-entry output register backed by a one-entry skid buffer.
module idu_pipe #(
    parameter int XLEN  = 32,
    parameter int RVE   = 0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, and data is held while valid & !ready.

    typedef enum logic [2:0] {
        T_R = 3'b000,
        T_I = 3'b001,
        T_S = 3'b010,
        T_B = 3'b011,
        T_U = 3'b100,
        T_J = 3'b101,
        T_N = 3'b110
    } inst_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        inst_type_e      typ;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{pc: '0, rs1: '0, rs2: '0, rd: '0, imm: '0,
                                     typ: T_N, illegal: 1'b0};

    entry_t            dec;
    logic              use_rd, use_rs1, use_rs2;
    logic signed [31:0] imm32;

    always_comb begin
        dec       = ENTRY_RST;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        imm32     = '0;
        dec.pc    = in_pc;
        dec.rs1   = in_inst[19:15];
        dec.rs2   = in_inst[24:20];
        dec.rd    = in_inst[11:7];
        case (in_inst[6:0])
            7'b0110011: begin
                dec.typ = T_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.typ = T_I; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            7'b0100011: begin
                dec.typ = T_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1100011: begin
                dec.typ = T_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec.typ = T_U; use_rd = 1'b1;
            end
            7'b1101111: begin
                dec.typ = T_J; use_rd = 1'b1;
            end
            default: begin
                dec.typ     = T_N;
                dec.illegal = 1'b1;
            end
        endcase
        case (dec.typ)
            T_I:     imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            T_S:     imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_B:     imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            T_U:     imm32 = {in_inst[31:12], 12'b0};
            T_J:     imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm = XLEN'(imm32);
        // RV32E only has x0..x15: a used register field with bit 4 set is illegal.
        if (RVE != 0) begin
            if ((use_rd && dec.rd[4]) || (use_rs1 && dec.rs1[4]) || (use_rs2 && dec.rs2[4]))
                dec.illegal = 1'b1;
        end
    end

    entry_t            out_q, skid_q;
    logic              out_valid_q, skid_valid_q, in_ready_q;
    logic [CNT_W-1:0]  cnt_q;

    logic in_fire, out_fire, load_out;
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign load_out = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            if (out_fire)
                cnt_q <= cnt_q + CNT_W'(1);
            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (load_out) begin
                // The skid entry is older than anything on the input, so it goes first.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end else if (in_fire) begin
                    out_q       <= dec;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = out_q.imm;
    assign out_type    = out_q.typ;
    assign out_illegal = out_q.illegal;
    assign dec_cnt     = cnt_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: an RV32I instance and an RV32E instance with a 4-bit counter
// share one stimulus stream and are checked against a queue-based reference model.
module tb_idu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        o0_in_ready, o0_out_valid, o0_illegal;
    logic [31:0] o0_pc, o0_imm, o0_cnt;
    logic [4:0]  o0_rs1, o0_rs2, o0_rd;
    logic [2:0]  o0_type;

    logic        o1_in_ready, o1_out_valid, o1_illegal;
    logic [31:0] o1_pc, o1_imm;
    logic [3:0]  o1_cnt;
    logic [4:0]  o1_rs1, o1_rs2, o1_rd;
    logic [2:0]  o1_type;

    idu_pipe #(.XLEN(32), .RVE(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o0_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(o0_out_valid), .out_ready(out_ready), .out_pc(o0_pc),
        .out_rs1(o0_rs1), .out_rs2(o0_rs2), .out_rd(o0_rd), .out_imm(o0_imm),
        .out_type(o0_type), .out_illegal(o0_illegal), .dec_cnt(o0_cnt)
    );

    idu_pipe #(.XLEN(32), .RVE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(o1_out_valid), .out_ready(out_ready), .out_pc(o1_pc),
        .out_rs1(o1_rs1), .out_rs2(o1_rs2), .out_rd(o1_rd), .out_imm(o1_imm),
        .out_type(o1_type), .out_illegal(o1_illegal), .dec_cnt(o1_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill0, ill1;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t m;
        logic u_rd, u_rs1, u_rs2;
        logic signed [31:0] s;
        m.pc = pc; m.rs1 = i[19:15]; m.rs2 = i[24:20]; m.rd = i[11:7];
        u_rd = 0; u_rs1 = 0; u_rs2 = 0;
        case (i[6:0])
            7'h33:                      begin m.typ = 3'd0; u_rd = 1; u_rs1 = 1; u_rs2 = 1; end
            7'h13, 7'h03, 7'h67, 7'h73: begin m.typ = 3'd1; u_rd = 1; u_rs1 = 1; end
            7'h23:                      begin m.typ = 3'd2; u_rs1 = 1; u_rs2 = 1; end
            7'h63:                      begin m.typ = 3'd3; u_rs1 = 1; u_rs2 = 1; end
            7'h37, 7'h17:               begin m.typ = 3'd4; u_rd = 1; end
            7'h6f:                      begin m.typ = 3'd5; u_rd = 1; end
            default:                    m.typ = 3'd6;
        endcase
        case (m.typ)
            3'd1:    s = $signed(i[31:20]);
            3'd2:    s = $signed({i[31:25], i[11:7]});
            3'd3:    s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            3'd4:    s = $signed({i[31:12], 12'h000});
            3'd5:    s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            default: s = 0;
        endcase
        m.imm  = s;
        m.ill0 = (m.typ == 3'd6);
        m.ill1 = m.ill0 || (u_rd && i[11]) || (u_rs1 && i[19]) || (u_rs2 && i[24]);
        return m;
    endfunction

    // Up to two entries in flight; a transfer on each side pops/pushes the FIFO.
    always @(posedge clk or negedge rst_n) begin
        bit o_fire, i_fire;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            o_fire = out_ready && (exp_q.size() > 0);
            i_fire = in_valid && (exp_q.size() < 2);
            if (o_fire) exp_cnt++;
            if (flush) exp_q.delete();
            else begin
                if (o_fire) void'(exp_q.pop_front());
                if (i_fire) exp_q.push_back(model(in_inst, in_pc));
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid0", o0_out_valid, 0); chk("rst_in_ready0", o0_in_ready, 1);
        chk("rst_cnt0", o0_cnt, 0);             chk("rst_type0", o0_type, 3'b110);
        chk("rst_pc0", o0_pc, 0);               chk("rst_imm0", o0_imm, 0);
        chk("rst_regs0", {o0_rs1, o0_rs2, o0_rd, o0_illegal}, 0);
        chk("rst_out_valid1", o1_out_valid, 0); chk("rst_in_ready1", o1_in_ready, 1);
        chk("rst_cnt1", o1_cnt, 0);             chk("rst_type1", o1_type, 3'b110);
    endtask

    always @(negedge clk) begin
        if (!rst_n) chk_reset_vals();
        else begin
            chk("in_ready0", o0_in_ready, exp_q.size() < 2);
            chk("in_ready1", o1_in_ready, exp_q.size() < 2);
            chk("out_valid0", o0_out_valid, exp_q.size() > 0);
            chk("out_valid1", o1_out_valid, exp_q.size() > 0);
            chk("dec_cnt0", o0_cnt, exp_cnt);
            chk("dec_cnt1", o1_cnt, exp_cnt % 16);
            if (exp_q.size() > 0) begin
                chk("pc0", o0_pc, exp_q[0].pc);     chk("pc1", o1_pc, exp_q[0].pc);
                chk("imm0", o0_imm, exp_q[0].imm);  chk("imm1", o1_imm, exp_q[0].imm);
                chk("type0", o0_type, exp_q[0].typ); chk("type1", o1_type, exp_q[0].typ);
                chk("regs0", {o0_rs1, o0_rs2, o0_rd},
                    {exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rd});
                chk("regs1", {o1_rs1, o1_rs2, o1_rd},
                    {exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rd});
                chk("illegal0", o0_illegal, exp_q[0].ill0);
                chk("illegal1", o1_illegal, exp_q[0].ill1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
        logic [31:0] r;
        int          pick;
        r    = $urandom;
        pick = $urandom_range(0, 11);
        if (pick < 10) r[6:0] = ops[pick];
        return r;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // addi x1,x0,5
        out_ready = 1'b1;
        send(32'h00500093, 32'h100);
        tick();
        chk("addi_valid", o0_out_valid, 1); chk("addi_type", o0_type, 3'b001);
        chk("addi_rd", o0_rd, 1);           chk("addi_rs1", o0_rs1, 0);
        chk("addi_imm", o0_imm, 32'h5);     chk("addi_ill", o0_illegal, 0);
        chk("addi_cnt_before", o0_cnt, 0);
        in_valid = 1'b0;
        tick();
        chk("addi_cnt_after", o0_cnt, 1);

        // sw, lui, jal back to back
        send(32'hFE20AE23, 32'h104); tick();
        chk("sw_type", o0_type, 3'b010);  chk("sw_imm", o0_imm, 32'hFFFFFFFC);
        send(32'h123452B7, 32'h108); tick();
        chk("lui_type", o0_type, 3'b100); chk("lui_imm", o0_imm, 32'h12345000);
        chk("lui_rd", o0_rd, 5);          chk("lui_valid", o0_out_valid, 1);
        send(32'h008000EF, 32'h10C); tick();
        chk("jal_type", o0_type, 3'b101); chk("jal_imm", o0_imm, 32'h8);
        chk("jal_rd", o0_rd, 1);          chk("jal_valid", o0_out_valid, 1);

        // all-zero word is illegal
        send(32'h00000000, 32'h110); tick();
        chk("zero_type", o0_type, 3'b110); chk("zero_ill", o0_illegal, 1);
        chk("zero_imm", o0_imm, 0);

        // RV32E register limits
        send(32'h01000093, 32'h114); tick();
        chk("rve_ok_ill", o1_illegal, 0);  chk("rve_ok_imm", o1_imm, 32'h10);
        send(32'h00000893, 32'h118); tick();
        chk("rve_bad_ill", o1_illegal, 1); chk("rve_bad_type", o1_type, 3'b001);
        chk("rv32i_x17_ill", o0_illegal, 0);
        in_valid = 1'b0;
        tick();

        // backpressure with a fresh counter
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        out_ready = 1'b0;
        send(32'h00100093, 32'h200); tick();
        chk("bp_out_a", o0_pc, 32'h200); chk("bp_rdy_a", o0_in_ready, 1);
        send(32'h00200093, 32'h204); tick();
        chk("bp_rdy_b", o0_in_ready, 0); chk("bp_hold_b", o0_pc, 32'h200);
        send(32'h00300093, 32'h208); tick();
        chk("bp_rdy_c", o0_in_ready, 0); chk("bp_hold_c", o0_pc, 32'h200);
        out_ready = 1'b1; tick();
        chk("bp_drain_b", o0_pc, 32'h204); chk("bp_rdy_again", o0_in_ready, 1);
        tick();
        chk("bp_drain_c", o0_pc, 32'h208);
        in_valid = 1'b0; tick();
        chk("bp_empty", o0_out_valid, 0); chk("bp_cnt", o0_cnt, 3);

        // flush with output and skid full and input offered
        out_ready = 1'b0;
        send(32'h00400093, 32'h300); tick();
        send(32'h00500093, 32'h304); tick();
        send(32'h00600093, 32'h308); flush = 1'b1; tick();
        chk("fl_valid", o0_out_valid, 0); chk("fl_rdy", o0_in_ready, 1);
        chk("fl_cnt", o0_cnt, 3);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl_stays_empty", o0_out_valid, 0);

        // flush coinciding with an output transfer still counts it
        out_ready = 1'b1;
        send(32'h00700093, 32'h30C); tick();
        send(32'h00800093, 32'h310); flush = 1'b1; tick();
        chk("fl_hs_valid", o0_out_valid, 0); chk("fl_hs_cnt", o0_cnt, 4);
        flush = 1'b0; in_valid = 1'b0; tick();

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(32'h00900093, 32'h400); tick();
        send(32'h00A00093, 32'h404); tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFFFFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
